// File: rtl/mem_access_controller.sv
// -----------------------------------------------------------------------------
// mem_access_controller
//
// Stage-4 data-memory access sequencer for an RV32 pipeline. A load or store
// request is checked for legality (size encoding and natural alignment),
// latched, and presented to a word-wide data memory with byte enables. The
// pipeline is stalled until the memory answers or a cycle budget runs out.
// Loads are aligned and sign/zero-extended into LOAD_DATA; stores are
// lane-replicated so the memory only has to honour DMEM_BYTEEN.
//
// Parameters
//   MAX_WAIT        ACCESS cycles allowed before a timeout fault (1..255)
//
// Ports
//   CLK, RESET      clock (rising edge), asynchronous active-high reset
//   MEM_READ/WRITE  load / store request from stage 4 (write wins if both)
//   FUNCT3          RV32 load/store size and sign encoding
//   ADDRESS         byte address
//   WRITE_DATA      right-aligned store data
//   DMEM_BUSYWAIT   memory busy; low means the access completes this cycle
//   DMEM_READDATA   word returned by memory
//   DMEM_READ/WRITE registered memory strobes, high only in ACCESS
//   DMEM_ADDRESS    word-aligned address
//   DMEM_WRITEDATA  lane-replicated store data
//   DMEM_BYTEEN     byte enables, bit i = byte lane i, non-zero only in ACCESS
//   LOAD_DATA       aligned, extended load result
//   STALL           freeze pipeline stages 1-4
//   ACCESS_FAULT    illegal request (IDLE) or timeout (DONE pulse)
// -----------------------------------------------------------------------------
module mem_access_controller #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  input  logic        DMEM_BUSYWAIT,
  input  logic [31:0] DMEM_READDATA,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [31:0] DMEM_ADDRESS,
  output logic [31:0] DMEM_WRITEDATA,
  output logic [3:0]  DMEM_BYTEEN,
  output logic [31:0] LOAD_DATA,
  output logic        STALL,
  output logic        ACCESS_FAULT
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  // Count value seen during the final allowed ACCESS cycle.
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_store_q, is_store_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] load_q, load_d;
  logic        timeout_q, timeout_d;

  logic        req;
  logic        legal;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        stall;
  logic        fault;

  assign req = MEM_READ | MEM_WRITE;

  // Legality: stores have no unsigned variants; halfwords/words need natural
  // alignment.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    legal = 1'b0;
    case (FUNCT3)
      3'b000:  legal = 1'b1;
      3'b100:  legal = ~MEM_WRITE;
      3'b001:  legal = ~ADDRESS[0];
      3'b101:  legal = ~MEM_WRITE & ~ADDRESS[0];
      3'b010:  legal = (ADDRESS[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Byte enables and replicated store data, computed from the live request so
  // they can be latched on the IDLE -> ACCESS edge.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = WRITE_DATA;
    case (FUNCT3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << ADDRESS[1:0];
        lane_wdata = {4{WRITE_DATA[7:0]}};
      end
      2'b01: begin
        lane_be    = ADDRESS[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{WRITE_DATA[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = WRITE_DATA;
      end
    endcase
  end

  // Load alignment and extension from the latched address and size.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = DMEM_READDATA[7:0];
      2'b01:   byte_sel = DMEM_READDATA[15:8];
      2'b10:   byte_sel = DMEM_READDATA[23:16];
      default: byte_sel = DMEM_READDATA[31:24];
    endcase
    half_sel = addr_q[1] ? DMEM_READDATA[31:16] : DMEM_READDATA[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = DMEM_READDATA;
    endcase
  end

  // Next-state and combinational outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    is_store_d = is_store_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    be_d       = be_q;
    load_d     = load_q;
    timeout_d  = timeout_q;
    stall      = 1'b0;
    fault      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (req) begin
          if (legal) begin
            stall      = 1'b1;
            addr_d     = ADDRESS;
            funct3_d   = FUNCT3;
            wdata_d    = lane_wdata;
            is_store_d = MEM_WRITE;
            rd_d       = ~MEM_WRITE;
            wr_d       = MEM_WRITE;
            be_d       = lane_be;
            state_d    = ACCESS;
          end else begin
            fault = 1'b1;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (!DMEM_BUSYWAIT) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          be_d    = 4'b0000;
          if (!is_store_q) load_d = load_ext;
          state_d = DONE;
        end else if (cnt_q == LAST_CNT) begin
          // Memory never answered: abandon and report in DONE.
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          be_d      = 4'b0000;
          if (!is_store_q) load_d = 32'd0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // The request is still asserted here; it belongs to the instruction
        // just finished, so it is deliberately ignored.
        fault     = timeout_q;
        timeout_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 32'd0;
      funct3_q   <= 3'd0;
      wdata_q    <= 32'd0;
      is_store_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      be_q       <= 4'b0000;
      load_q     <= 32'd0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      wdata_q    <= wdata_d;
      is_store_q <= is_store_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      be_q       <= be_d;
      load_q     <= load_d;
      timeout_q  <= timeout_d;
    end
  end

  assign DMEM_READ      = rd_q;
  assign DMEM_WRITE     = wr_q;
  assign DMEM_ADDRESS   = {addr_q[31:2], 2'b00};
  assign DMEM_WRITEDATA = wdata_q;
  assign DMEM_BYTEEN    = be_q;
  assign LOAD_DATA      = load_q;
  // Combinational outputs are masked so reset takes effect without an edge.
  assign STALL          = stall & ~RESET;
  assign ACCESS_FAULT   = fault & ~RESET;

endmodule

// File: tb/tb_mem_access_controller.sv
// -----------------------------------------------------------------------------
// tb_mem_access_controller
//
// Directed testbench for mem_access_controller (MAX_WAIT = 4). Inputs are
// driven 1 ns after the rising edge and outputs sampled on the falling edge.
// The bench plays the memory: it drives DMEM_BUSYWAIT high from the request
// cycle for a chosen number of ACCESS cycles, then low.
// -----------------------------------------------------------------------------
module tb_mem_access_controller;

  logic        CLK;
  logic        RESET;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic        DMEM_BUSYWAIT;
  logic [31:0] DMEM_READDATA;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [31:0] DMEM_ADDRESS;
  logic [31:0] DMEM_WRITEDATA;
  logic [3:0]  DMEM_BYTEEN;
  logic [31:0] LOAD_DATA;
  logic        STALL;
  logic        ACCESS_FAULT;

  mem_access_controller #(.MAX_WAIT(4)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .MEM_READ       (MEM_READ),
    .MEM_WRITE      (MEM_WRITE),
    .FUNCT3         (FUNCT3),
    .ADDRESS        (ADDRESS),
    .WRITE_DATA     (WRITE_DATA),
    .DMEM_BUSYWAIT  (DMEM_BUSYWAIT),
    .DMEM_READDATA  (DMEM_READDATA),
    .DMEM_READ      (DMEM_READ),
    .DMEM_WRITE     (DMEM_WRITE),
    .DMEM_ADDRESS   (DMEM_ADDRESS),
    .DMEM_WRITEDATA (DMEM_WRITEDATA),
    .DMEM_BYTEEN    (DMEM_BYTEEN),
    .LOAD_DATA      (LOAD_DATA),
    .STALL          (STALL),
    .ACCESS_FAULT   (ACCESS_FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Results of the most recent run_req call.
  int          stall_cnt, rd_cnt, wr_cnt;
  logic        unstable, finished;
  logic [31:0] seen_addr, seen_wd;
  logic [3:0]  seen_be;
  logic [31:0] end_load;
  logic        end_fault;
  logic [5:0]  end_strobes;
  logic [31:0] exp_load;

  // Present one request (starting at posedge+1) and follow it until STALL is
  // low on a falling edge (DONE, or IDLE for a faulted request). Returns at
  // posedge+1 of the following cycle with the request still driven.
  task automatic run_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int busy_access);
    int   cyc;
    logic first;
    MEM_READ      = rd;
    MEM_WRITE     = wr;
    FUNCT3        = f3;
    ADDRESS       = addr;
    WRITE_DATA    = wdata;
    DMEM_READDATA = rdata;
    stall_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    unstable = 1'b0; finished = 1'b0; first = 1'b1;
    seen_addr = '0; seen_wd = '0; seen_be = '0;
    end_load = '0; end_fault = 1'b0; end_strobes = '0;
    cyc = 0;
    while (!finished && cyc < 20) begin
      DMEM_BUSYWAIT = (busy_access > 0) && (cyc <= busy_access);
      @(negedge CLK);
      if (STALL) stall_cnt++;
      if (DMEM_READ) rd_cnt++;
      if (DMEM_WRITE) wr_cnt++;
      if (DMEM_READ || DMEM_WRITE) begin
        if (first) begin
          seen_addr = DMEM_ADDRESS; seen_wd = DMEM_WRITEDATA; seen_be = DMEM_BYTEEN;
          first = 1'b0;
        end else if (seen_addr !== DMEM_ADDRESS || seen_wd !== DMEM_WRITEDATA ||
                     seen_be !== DMEM_BYTEEN) begin
          unstable = 1'b1;
        end
      end
      if (!STALL) begin
        finished    = 1'b1;
        end_load    = LOAD_DATA;
        end_fault   = ACCESS_FAULT;
        end_strobes = {DMEM_READ, DMEM_WRITE, DMEM_BYTEEN};
      end
      @(posedge CLK); #1;
      cyc++;
    end
    DMEM_BUSYWAIT = 1'b0;
  endtask

  // Drop the request for one cycle and check the controller is quiet.
  task automatic idle_cycle(input string tag);
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    @(negedge CLK);
    check({tag, "_idle_stall"}, STALL, 1'b0);
    check({tag, "_idle_fault"}, ACCESS_FAULT, 1'b0);
    @(posedge CLK); #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    run_req(1'b1, 1'b0, f3, addr, 32'h0, rdata, 0);
    check({tag, "_done"},  finished, 1'b1);
    check({tag, "_stall"}, stall_cnt, 2);
    check({tag, "_rd"},    rd_cnt, 1);
    check({tag, "_addr"},  seen_addr, {addr[31:2], 2'b00});
    check({tag, "_load"},  end_load, exp);
    check({tag, "_fault"}, end_fault, 1'b0);
    exp_load = exp;
  endtask

  task automatic do_store(input string tag, input logic both, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_wd, input logic [3:0] exp_be);
    run_req(both, 1'b1, f3, addr, wdata, 32'hFFFF_FFFF, 0);
    check({tag, "_done"},  finished, 1'b1);
    check({tag, "_stall"}, stall_cnt, 2);
    check({tag, "_wr"},    wr_cnt, 1);
    check({tag, "_rd"},    rd_cnt, 0);
    check({tag, "_wd"},    seen_wd, exp_wd);
    check({tag, "_be"},    seen_be, exp_be);
    check({tag, "_load"},  end_load, exp_load);
  endtask

  task automatic do_illegal(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
    run_req(rd, wr, f3, addr, 32'h1234_5678, 32'h0, 0);
    check({tag, "_stall"}, stall_cnt, 0);
    check({tag, "_fault"}, end_fault, 1'b1);
    check({tag, "_strb"},  end_strobes, 6'd0);
    check({tag, "_load"},  end_load, exp_load);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; MEM_READ = 1'b1; MEM_WRITE = 1'b0; FUNCT3 = 3'b010;
    ADDRESS = 32'h0000_0100; WRITE_DATA = 32'h0; DMEM_BUSYWAIT = 1'b0;
    DMEM_READDATA = 32'h0; exp_load = 32'h0;

    // Reset state, with a legal request pending that must not stall.
    repeat (2) @(negedge CLK);
    check("rst_stall", STALL, 1'b0);
    check("rst_fault", ACCESS_FAULT, 1'b0);
    check("rst_strb",  {DMEM_READ, DMEM_WRITE, DMEM_BYTEEN}, 6'd0);
    check("rst_addr",  DMEM_ADDRESS, 32'h0);
    check("rst_wd",    DMEM_WRITEDATA, 32'h0);
    check("rst_load",  LOAD_DATA, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle_cycle("post_rst");

    // LB at 0x1003, busy for the request cycle plus two ACCESS cycles.
    run_req(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 2);
    check("lb_done",   finished, 1'b1);
    check("lb_stall",  stall_cnt, 4);
    check("lb_rd",     rd_cnt, 3);
    check("lb_wr",     wr_cnt, 0);
    check("lb_addr",   seen_addr, 32'h0000_1000);
    check("lb_be",     seen_be, 4'b1000);
    check("lb_stable", unstable, 1'b0);
    check("lb_load",   end_load, 32'hFFFF_FF80);
    check("lb_fault",  end_fault, 1'b0);
    check("lb_dstrb",  end_strobes, 6'd0);
    exp_load = 32'hFFFF_FF80;

    // SH at 0x2002, zero wait.
    do_store("sh", 1'b0, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100);
    check("sh_addr", seen_addr, 32'h0000_2000);

    // Illegal requests: fault in IDLE, no strobe, LOAD_DATA untouched.
    do_illegal("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_3001);
    do_illegal("lw_mis2", 1'b1, 1'b0, 3'b010, 32'h0000_3002);
    do_illegal("sh_mis", 1'b0, 1'b1, 3'b001, 32'h0000_2003);
    do_illegal("sbu",    1'b0, 1'b1, 3'b100, 32'h0000_2000);
    do_illegal("ld_f3",  1'b1, 1'b0, 3'b011, 32'h0000_2000);
    idle_cycle("ill");

    // Load extraction variants.
    do_load("lh",  3'b001, 32'h0000_6002, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load("lbu", 3'b100, 32'h0000_6001, 32'h0000_9A00, 32'h0000_009A);
    do_load("lhu", 3'b101, 32'h0000_6000, 32'hFFFF_8123, 32'h0000_8123);
    do_load("lbp", 3'b000, 32'h0000_6000, 32'hFFFF_FF7F, 32'h0000_007F);

    // Store lane variants.
    do_store("sb",  1'b0, 3'b000, 32'h0000_7001, 32'h1234_56A5, 32'hA5A5_A5A5, 4'b0010);
    do_store("sh0", 1'b0, 3'b001, 32'h0000_7000, 32'h0000_CAFE, 32'hCAFE_CAFE, 4'b0011);
    do_store("sw",  1'b0, 3'b010, 32'h0000_7004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);

    // Longest wait that still completes: busy for MAX_WAIT-1 ACCESS cycles.
    run_req(1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0, 32'h0BAD_F00D, 3);
    check("edge_stall", stall_cnt, 5);
    check("edge_rd",    rd_cnt, 4);
    check("edge_fault", end_fault, 1'b0);
    check("edge_load",  end_load, 32'h0BAD_F00D);
    exp_load = 32'h0BAD_F00D;

    // LHU with memory stuck busy: timeout after MAX_WAIT ACCESS cycles.
    run_req(1'b1, 1'b0, 3'b101, 32'h0000_5002, 32'h0, 32'h1234_5678, 100);
    check("to_done",  finished, 1'b1);
    check("to_stall", stall_cnt, 5);
    check("to_rd",    rd_cnt, 4);
    check("to_fault", end_fault, 1'b1);
    check("to_load",  end_load, 32'h0);
    check("to_dstrb", end_strobes, 6'd0);
    exp_load = 32'h0;
    idle_cycle("to");

    // Give LOAD_DATA a non-zero value so reset clearing is visible.
    do_load("pre_rst", 3'b010, 32'h0000_8004, 32'h1122_3344, 32'h1122_3344);

    // Reset pulsed during the second ACCESS cycle of a load.
    MEM_READ = 1'b1; MEM_WRITE = 1'b0; FUNCT3 = 3'b010;
    ADDRESS = 32'h0000_4000; DMEM_BUSYWAIT = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #2;
    check("ar_pre_rd",    DMEM_READ, 1'b1);
    check("ar_pre_stall", STALL, 1'b1);
    RESET = 1'b1;
    #1;
    check("ar_stall", STALL, 1'b0);
    check("ar_strb",  {DMEM_READ, DMEM_WRITE, DMEM_BYTEEN}, 6'd0);
    check("ar_addr",  DMEM_ADDRESS, 32'h0);
    check("ar_load",  LOAD_DATA, 32'h0);
    exp_load = 32'h0;
    @(negedge CLK);
    MEM_READ = 1'b0; DMEM_BUSYWAIT = 1'b0; RESET = 1'b0;
    @(posedge CLK); #1;
    idle_cycle("ar");
    do_load("ar_next", 3'b010, 32'h0000_4004, 32'h1234_5678, 32'h1234_5678);

    // LW then SW back to back; SW issued with MEM_READ also high.
    do_load("b2b_lw", 3'b010, 32'h0000_9000, 32'hA1B2_C3D4, 32'hA1B2_C3D4);
    do_store("b2b_sw", 1'b1, 3'b010, 32'h0000_9004, 32'h55AA_55AA, 32'h55AA_55AA, 4'b1111);
    idle_cycle("end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
